// File: rtl/target_sector_finder_pkg.sv
// Shared definitions for the target sector finder.
//   state_t     : FSM state encoding (IDLE, LATCH, CMP, FINISH)
//   COORD_W     : width of the signed x/y offsets
//   STEP_DEG    : angular bin width in degrees
//   ANGLE_180/360 : 9-bit angle constants for the quadrant mapping
//   abs_sat()   : |v| of a 9-bit signed offset, saturated to 255
package target_sector_finder_pkg;

   localparam int COORD_W  = 9;
   localparam int STEP_DEG = 15;

   localparam logic [8:0] ANGLE_180 = 9'd180;
   localparam logic [8:0] ANGLE_360 = 9'd360;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LATCH  = 2'd1,
      CMP    = 2'd2,
      FINISH = 2'd3
   } state_t;

   // -256 has no 8-bit magnitude, so it is clamped to 255.
   function automatic logic [7:0] abs_sat(input logic signed [COORD_W-1:0] v);
      logic signed [COORD_W:0] mag;
      mag = (v < 0) ? -{v[COORD_W-1], v} : {v[COORD_W-1], v};
      return (mag > 10'sd255) ? 8'd255 : mag[7:0];
   endfunction

endpackage

// File: rtl/target_sector_finder_if.sv
// Request/result bundle between a requester and target_sector_finder.
//   start  : request pulse (sampled only when the finder is idle)
//   x, y   : signed target offsets
//   busy   : operation in progress
//   done   : one-cycle result strobe
//   angle  : bearing in degrees, multiple of 15 in 0..345
//   sector : first-quadrant bin 0..6
//   error  : x == 0 and y == 0 (valid with done)
interface target_sector_finder_if;
   import target_sector_finder_pkg::*;

   logic                       start;
   logic signed [COORD_W-1:0]  x;
   logic signed [COORD_W-1:0]  y;
   logic                       busy;
   logic                       done;
   logic [8:0]                 angle;
   logic [2:0]                 sector;
   logic                       error;

   modport master (output start, x, y, input busy, done, angle, sector, error);
   modport slave  (input start, x, y, output busy, done, angle, sector, error);
endinterface

// File: rtl/calc_rtan_00_90_15.sv
// Combinational r*tan(theta) for theta = 0..90 in 15-degree steps.
//   r          : 9-bit unsigned radius
//   rtan_00..90: floor(r*tan(theta)) as 11-bit signed, saturated to 1023;
//                rtan_90 is always the saturation value.
// tan() is held as Q12 constants truncated downward so the product floors.
module calc_rtan_00_90_15 (
   input  logic [8:0]         r,
   output logic signed [10:0] rtan_00,
   output logic signed [10:0] rtan_15,
   output logic signed [10:0] rtan_30,
   output logic signed [10:0] rtan_45,
   output logic signed [10:0] rtan_60,
   output logic signed [10:0] rtan_75,
   output logic signed [10:0] rtan_90
);

   function automatic logic signed [10:0] scale(input logic [8:0] rr, input logic [15:0] tan_q12);
      logic [24:0] p;
      p = (25'(rr) * 25'(tan_q12)) >> 12;
      return (p > 25'd1023) ? 11'sd1023 : signed'(p[10:0]);
   endfunction

   assign rtan_00 = 11'sd0;
   assign rtan_15 = scale(r, 16'd1097);
   assign rtan_30 = scale(r, 16'd2364);
   assign rtan_45 = scale(r, 16'd4096);
   assign rtan_60 = scale(r, 16'd7094);
   assign rtan_75 = scale(r, 16'd15286);
   assign rtan_90 = 11'sd1023;

endmodule

// File: rtl/target_sector_finder.sv
// Quantizes a signed (x, y) target offset into a 15-degree bearing.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : start/x/y request in; busy/done/angle/sector/error out
// |y| is compared against r*tan thresholds (r = |x|) one per cycle, so the
// latency grows with the resulting first-quadrant bin.
module target_sector_finder
   import target_sector_finder_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   target_sector_finder_if.slave bus
);

   state_t                    state_q, state_d;
   logic signed [COORD_W-1:0] xr_q, xr_d, yr_q, yr_d;
   logic [7:0]                ax_q, ax_d, ay_q, ay_d;
   logic                      qx_q, qx_d, qy_q, qy_d;
   logic [2:0]                idx_q, idx_d, k_q, k_d;
   logic                      zero_q, zero_d;
   logic                      busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [8:0]                angle_q, angle_d;
   logic [2:0]                sector_q, sector_d;

   logic signed [10:0] rtan_00_unused, rtan_90_unused;
   logic signed [10:0] rtan_15, rtan_30, rtan_45, rtan_60, rtan_75;
   logic signed [10:0] thr;
   logic [8:0]         a_deg;

   calc_rtan_00_90_15 u_rtan (
      .r       ({1'b0, ax_q}),
      .rtan_00 (rtan_00_unused),
      .rtan_15 (rtan_15),
      .rtan_30 (rtan_30),
      .rtan_45 (rtan_45),
      .rtan_60 (rtan_60),
      .rtan_75 (rtan_75),
      .rtan_90 (rtan_90_unused)
   );

   // Threshold for the bin boundary currently under test: T[idx] = rtan_{15(idx+1)}.
   always_comb begin
      unique case (idx_q)
         3'd0:    thr = rtan_15;
         3'd1:    thr = rtan_30;
         3'd2:    thr = rtan_45;
         3'd3:    thr = rtan_60;
         default: thr = rtan_75;
      endcase
   end

   assign a_deg = 9'(k_q) * 9'(STEP_DEG);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d  = state_q;
      xr_d     = xr_q;
      yr_d     = yr_q;
      ax_d     = ax_q;
      ay_d     = ay_q;
      qx_d     = qx_q;
      qy_d     = qy_q;
      idx_d    = idx_q;
      k_d      = k_q;
      zero_d   = zero_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      error_d  = error_q;
      angle_d  = angle_q;
      sector_d = sector_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               xr_d    = bus.x;
               yr_d    = bus.y;
               busy_d  = 1'b1;
               error_d = 1'b0;
               state_d = LATCH;
            end
         end
         LATCH: begin
            ax_d   = abs_sat(xr_q);
            ay_d   = abs_sat(yr_q);
            qx_d   = xr_q[COORD_W-1];
            qy_d   = yr_q[COORD_W-1];
            idx_d  = 3'd0;
            zero_d = 1'b0;
            // x == 0 makes every r*tan threshold zero, so the bin is decided here.
            if (ax_d == 8'd0 && ay_d == 8'd0) begin
               k_d     = 3'd0;
               zero_d  = 1'b1;
               state_d = FINISH;
            end else if (ax_d == 8'd0) begin
               k_d     = 3'd6;
               state_d = FINISH;
            end else begin
               state_d = CMP;
            end
         end
         CMP: begin
            // A value equal to a threshold falls into the upper bin.
            if ($signed({3'b000, ay_q}) < thr) begin
               k_d     = idx_q;
               state_d = FINISH;
            end else if (idx_q == 3'd4) begin
               k_d     = 3'd5;
               state_d = FINISH;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         FINISH: begin
            sector_d = k_q;
            error_d  = zero_q;
            // First-quadrant floor bin mirrored into the other quadrants.
            unique case ({qx_q, qy_q})
               2'b00:   angle_d = a_deg;
               2'b10:   angle_d = ANGLE_180 - a_deg;
               2'b11:   angle_d = ANGLE_180 + a_deg;
               default: angle_d = (a_deg == 9'd0) ? 9'd0 : ANGLE_360 - a_deg;
            endcase
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order or other processes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         xr_q     <= '0;
         yr_q     <= '0;
         ax_q     <= '0;
         ay_q     <= '0;
         qx_q     <= 1'b0;
         qy_q     <= 1'b0;
         idx_q    <= '0;
         k_q      <= '0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         angle_q  <= '0;
         sector_q <= '0;
      end else begin
         state_q  <= state_d;
         xr_q     <= xr_d;
         yr_q     <= yr_d;
         ax_q     <= ax_d;
         ay_q     <= ay_d;
         qx_q     <= qx_d;
         qy_q     <= qy_d;
         idx_q    <= idx_d;
         k_q      <= k_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         angle_q  <= angle_d;
         sector_q <= sector_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.error  = error_q;
   assign bus.angle  = angle_q;
   assign bus.sector = sector_q;

endmodule
